rate_match_buf: RTL and testbench

//  Parametrised coefficient/pixel buffer between the DCT/quantiser, the entropy coder and the IDCT.

---
 rtl/rate_match_buf.sv | 211 +++++++++++++++++++++
 tb/tb_rate_match_buf.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_match_buf.sv
// Coefficient/pixel buffer: encode-mode scratch RAM for the entropy coder, decode-mode
// block FIFO that drains IDCT samples at a fixed rate and saturates them to pixels.
module rate_match_buf #(
  parameter int IN_W      = 13,
  parameter int OUT_W     = 8,
  parameter int FRAC_SH   = 2,
  parameter int BLK_LOG2  = 6,
  parameter int BLK_LAST  = 63,
  parameter int NBUF      = 2,
  parameter int RATE_LOG2 = 2,
  parameter int ENC_AW    = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                dct_flag,
  input  logic [7:0]          q_data,
  input  logic                q_data_en,
  input  logic [BLK_LOG2-1:0] q_index,
  output logic                dct_q_ready,
  output logic [7:0]          dct_q_rdata,
  input  logic                entropy_enc_we,
  input  logic [ENC_AW-1:0]   entropy_enc_waddr,
  input  logic [7:0]          entropy_enc_wdata,
  input  logic [ENC_AW-1:0]   entropy_enc_raddr,
  output logic [7:0]          entropy_enc_rdata,
  input  logic [IN_W-1:0]     idct_data,
  input  logic                idct_data_en,
  input  logic [BLK_LOG2-1:0] idct_data_idx,
  input  logic                last_dec_blk,
  output logic                idct_ready,
  output logic [OUT_W-1:0]    decompress_data,
  output logic                decompress_data_en,
  output logic                decompress_finish,
  output logic                overflow
);

  localparam int PW    = $clog2(NBUF);
  localparam int AW    = PW + BLK_LOG2;
  localparam int DEPTH = NBUF << BLK_LOG2;
  localparam int DW    = (IN_W > 8) ? IN_W : 8;
  localparam int CW    = BLK_LOG2 + RATE_LOG2;
  localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (OUT_W - 1));
  localparam logic [CW-1:0] PH_MASK  = CW'((1 << RATE_LOG2) - 1);
  localparam logic [PW:0]   OCC_FULL = (PW + 1)'(NBUF);
  localparam logic [PW:0]   OCC_ONE  = (PW + 1)'(1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_wrPtr;
  logic [PW-1:0]     r_rdPtr;
  logic [PW:0]       r_occ;
  logic [NBUF-1:0]   r_last;
  logic              r_dctFlagPrev;
  logic              r_s1;
  logic              r_f1;
  logic              r_wrEn;
  logic [AW-1:0]     r_wrAddr;
  logic [DW-1:0]     r_wrData;
  logic [DW-1:0]     r_rdData;
  logic [DW-1:0]     r_mem [0:DEPTH-1];

  logic              w_draining;
  logic              w_strobe;
  logic              w_lastSample;
  logic              w_release;
  logic              w_flush;
  logic              w_full;
  logic              w_blkEnd;
  logic              w_decWr;
  logic              w_complete;
  logic              w_ovf;
  logic              w_wrEn;
  logic [AW-1:0]     w_wrAddr;
  logic [DW-1:0]     w_wrData;
  logic [AW-1:0]     w_rdAddr;
  logic [OUT_W-1:0]  w_pix;

  function automatic logic [OUT_W-1:0] saturate(input logic [IN_W-1:0] d);
    logic signed [IN_W-1:0] x;
    x = $signed(d) >>> FRAC_SH;
    if (int'(x) > SAT_MAX) return OUT_W'(SAT_MAX);
    if (int'(x) < SAT_MIN) return OUT_W'(SAT_MIN);
    return x[OUT_W-1:0];
  endfunction

  // A full FIFO drops incoming samples so the buffer being drained is never overwritten,
  // unless that buffer is released on the same clock.
  always_comb begin
    w_draining   = (r_state == DRAIN) && !dct_flag;
    w_strobe     = w_draining && ((r_cnt & PH_MASK) == '0);
    w_lastSample = (r_cnt[CW-1:RATE_LOG2] == '1);
    w_release    = w_draining && (r_cnt == '1);
    w_flush      = dct_flag && !r_dctFlagPrev && ((r_state == DRAIN) || (r_occ != '0));
    w_full       = (r_occ == OCC_FULL);
    w_decWr      = !dct_flag && idct_data_en && (!w_full || w_release);
    w_blkEnd     = !dct_flag && idct_data_en && (idct_data_idx == BLK_LOG2'(BLK_LAST));
    w_complete   = w_blkEnd && (!w_full || w_release);
    w_ovf        = w_blkEnd && w_full && !w_release;
    w_pix        = saturate(r_rdData[IN_W-1:0]);
    w_rdAddr     = dct_flag ? AW'(entropy_enc_raddr) : {r_rdPtr, r_cnt[CW-1:RATE_LOG2]};
  end

  always_comb begin
    w_wrEn   = 1'b0;
    w_wrAddr = '0;
    w_wrData = '0;
    if (dct_flag) begin
      if (q_data_en) begin
        w_wrEn   = 1'b1;
        w_wrAddr = AW'(q_index);
        w_wrData = DW'(q_data);
      end else if (entropy_enc_we) begin
        w_wrEn   = 1'b1;
        w_wrAddr = AW'(entropy_enc_waddr);
        w_wrData = DW'(entropy_enc_wdata);
      end
    end else if (w_decWr) begin
      w_wrEn   = 1'b1;
      w_wrAddr = {r_wrPtr, idct_data_idx};
      w_wrData = DW'(idct_data);
    end
  end

  always_ff @(posedge clock) begin
    if (r_wrEn) r_mem[r_wrAddr] <= r_wrData;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rdData <= '0;
    else          r_rdData <= r_mem[w_rdAddr];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state            <= IDLE;
      r_cnt              <= '0;
      r_wrPtr            <= '0;
      r_rdPtr            <= '0;
      r_occ              <= '0;
      r_last             <= '0;
      r_dctFlagPrev      <= 1'b0;
      r_s1               <= 1'b0;
      r_f1               <= 1'b0;
      r_wrEn             <= 1'b0;
      r_wrAddr           <= '0;
      r_wrData           <= '0;
      dct_q_ready        <= 1'b0;
      decompress_data    <= '0;
      decompress_data_en <= 1'b0;
      decompress_finish  <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      r_dctFlagPrev      <= dct_flag;
      r_wrEn             <= w_wrEn;
      r_wrAddr           <= w_wrAddr;
      r_wrData           <= w_wrData;
      dct_q_ready        <= dct_flag && q_data_en && (q_index == '1);
      r_s1               <= w_strobe;
      r_f1               <= w_strobe && w_lastSample && r_last[r_rdPtr];
      decompress_data_en <= r_s1;
      decompress_finish  <= r_f1;
      if (r_s1) decompress_data <= w_pix;
      if (w_ovf) overflow <= 1'b1;

      // Entering encode mode discards queued blocks; pixels already in the pipe still emerge.
      if (w_flush) begin
        r_state           <= IDLE;
        r_occ             <= '0;
        r_wrPtr           <= '0;
        r_rdPtr           <= '0;
        r_last            <= '0;
        r_f1              <= 1'b0;
        decompress_finish <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_occ != '0) begin
              r_state <= DRAIN;
              r_cnt   <= '0;
            end
          end
          DRAIN: begin
            if (!dct_flag) begin
              r_cnt <= r_cnt + CW'(1);
              if (w_release) begin
                r_rdPtr <= r_rdPtr + PW'(1);
                if (r_occ <= OCC_ONE) r_state <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
        if (w_release) r_last[r_rdPtr] <= 1'b0;
        if (w_complete) begin
          r_last[r_wrPtr] <= last_dec_blk;
          r_wrPtr         <= r_wrPtr + PW'(1);
        end
        if (w_complete && !w_release)      r_occ <= r_occ + OCC_ONE;
        else if (!w_complete && w_release) r_occ <= r_occ - OCC_ONE;
      end
    end
  end

  assign idct_ready        = (r_occ < OCC_FULL);
  assign entropy_enc_rdata = r_rdData[7:0];
  assign dct_q_rdata       = r_rdData[7:0];

endmodule

// File: tb/tb_rate_match_buf.sv
// Randomized bench for rate_match_buf: encode scratch RAM, decode FIFO drain,
// saturation, backpressure/overflow, continuous streaming, abort and reset.
module tb_rate_match_buf;

  localparam int RATE = 4;

  logic        clock;
  logic        reset_n;
  logic        dct_flag;
  logic [7:0]  q_data;
  logic        q_data_en;
  logic [5:0]  q_index;
  logic        dct_q_ready;
  logic [7:0]  dct_q_rdata;
  logic        entropy_enc_we;
  logic [7:0]  entropy_enc_waddr;
  logic [7:0]  entropy_enc_wdata;
  logic [7:0]  entropy_enc_raddr;
  logic [7:0]  entropy_enc_rdata;
  logic [12:0] idct_data;
  logic        idct_data_en;
  logic [5:0]  idct_data_idx;
  logic        last_dec_blk;
  logic        idct_ready;
  logic [7:0]  decompress_data;
  logic        decompress_data_en;
  logic        decompress_finish;
  logic        overflow;

  typedef struct {
    int pix;
    bit fin;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   blk[64];
  int   scr[8];
  int   checkCount  = 0;
  int   errorCount  = 0;
  int   cyc         = 0;
  int   lastPixCyc  = -1;
  int   firstPixCyc = -1;
  int   popCount    = 0;
  int   finCount    = 0;
  int   completeCyc = 0;

  rate_match_buf dut (
    .clock(clock), .reset_n(reset_n), .dct_flag(dct_flag),
    .q_data(q_data), .q_data_en(q_data_en), .q_index(q_index),
    .dct_q_ready(dct_q_ready), .dct_q_rdata(dct_q_rdata),
    .entropy_enc_we(entropy_enc_we), .entropy_enc_waddr(entropy_enc_waddr),
    .entropy_enc_wdata(entropy_enc_wdata), .entropy_enc_raddr(entropy_enc_raddr),
    .entropy_enc_rdata(entropy_enc_rdata),
    .idct_data(idct_data), .idct_data_en(idct_data_en), .idct_data_idx(idct_data_idx),
    .last_dec_blk(last_dec_blk), .idct_ready(idct_ready),
    .decompress_data(decompress_data), .decompress_data_en(decompress_data_en),
    .decompress_finish(decompress_finish), .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Pixel = floor(sample / 4) clamped to the signed 8-bit range.
  function automatic int refPixel(input int s);
    int x;
    if (s >= 0) x = s / 4;
    else        x = -((-s + 3) / 4);
    if (x > 127)  return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int randSample();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  task automatic pushBlock(input bit lastFlag);
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      e.pix = refPixel(blk[k]);
      e.fin = lastFlag && (k == 63);
      expQ.push_back(e);
    end
  endtask

  // Writes blk[] as one 64-sample block, one sample per clock, starting at the current negedge.
  task automatic applyStimulus(input bit lastFlag, input bit accepted);
    if (accepted) pushBlock(lastFlag);
    for (int k = 0; k < 64; k++) begin
      idct_data_en  = 1'b1;
      idct_data_idx = 6'(k);
      idct_data     = 13'(blk[k]);
      last_dec_blk  = lastFlag;
      @(negedge clock);
    end
    idct_data_en = 1'b0;
    last_dec_blk = 1'b0;
    completeCyc  = cyc;
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drained", expQ.size(), 0);
    repeat (8) @(negedge clock);
  endtask

  task automatic waitPixels(input int count, input int limit);
    int n;
    int base;
    n    = 0;
    base = popCount;
    while (popCount < base + count && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput("pixelsArrived", int'(popCount >= base + count), 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_dataEn"},  int'(decompress_data_en), 0);
    checkOutput({tag, "_data"},    int'(decompress_data), 0);
    checkOutput({tag, "_finish"},  int'(decompress_finish), 0);
    checkOutput({tag, "_overflow"}, int'(overflow), 0);
    checkOutput({tag, "_ready"},   int'(idct_ready), 1);
    checkOutput({tag, "_qReady"},  int'(dct_q_ready), 0);
    checkOutput({tag, "_rdata"},   int'(entropy_enc_rdata), 0);
  endtask

  // Pixel scoreboard: every strobe is matched against the expected queue in order.
  always @(negedge clock) begin
    if (reset_n) begin
      if (decompress_data_en) begin
        popCount++;
        if (firstPixCyc < 0) firstPixCyc = cyc;
        if (lastPixCyc >= 0) checkOutput("pixelGap", cyc - lastPixCyc, RATE);
        lastPixCyc = cyc;
        if (decompress_finish) finCount++;
        if (expQ.size() == 0) begin
          checkOutput("spuriousPixel", int'(decompress_data_en), 0);
        end else begin
          monE = expQ.pop_front();
          checkOutput("pixel", int'($signed(decompress_data)), monE.pix);
          checkOutput("finish", int'(decompress_finish), int'(monE.fin));
        end
      end else if (decompress_finish) begin
        finCount++;
        checkOutput("finishAlone", int'(decompress_finish), 0);
      end
    end
  end

  initial begin
    int finBase;
    int popBase;
    int abortCyc;
    int late;
    bit lf;

    reset_n           = 1'b0;
    dct_flag          = 1'b0;
    q_data            = '0;
    q_data_en         = 1'b0;
    q_index           = '0;
    entropy_enc_we    = 1'b0;
    entropy_enc_waddr = '0;
    entropy_enc_wdata = '0;
    entropy_enc_raddr = '0;
    idct_data         = '0;
    idct_data_en      = 1'b0;
    idct_data_idx     = '0;
    last_dec_blk      = 1'b0;

    repeat (3) @(negedge clock);
    checkResetOutputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Encode: coefficients 0..63, ready pulse after index 63.
    $display("[TB] encode mode");
    dct_flag = 1'b1;
    for (int i = 0; i < 64; i++) begin
      q_data_en = 1'b1;
      q_index   = 6'(i);
      q_data    = 8'(i);
      @(negedge clock);
      checkOutput("dctQReady", int'(dct_q_ready), int'(i == 63));
    end
    q_data_en = 1'b0;
    @(negedge clock);
    checkOutput("dctQReadyPulse", int'(dct_q_ready), 0);

    for (int j = 0; j < 8; j++) begin
      scr[j]            = int'($urandom_range(0, 255));
      entropy_enc_we    = 1'b1;
      entropy_enc_waddr = 8'(64 + j);
      entropy_enc_wdata = 8'(scr[j]);
      @(negedge clock);
    end
    q_data_en         = 1'b1;
    q_index           = 6'd10;
    q_data            = 8'hAA;
    entropy_enc_we    = 1'b1;
    entropy_enc_waddr = 8'd10;
    entropy_enc_wdata = 8'h55;
    @(negedge clock);
    q_data_en      = 1'b0;
    entropy_enc_we = 1'b0;
    repeat (2) @(negedge clock);

    entropy_enc_raddr = 8'd5;
    @(negedge clock);
    checkOutput("rdata5", int'(entropy_enc_rdata), 5);
    checkOutput("qRdata5", int'(dct_q_rdata), 5);
    entropy_enc_raddr = 8'd63;
    @(negedge clock);
    checkOutput("rdata63", int'(entropy_enc_rdata), 63);
    entropy_enc_raddr = 8'd10;
    @(negedge clock);
    checkOutput("qWinsOverWe", int'(entropy_enc_rdata), 170);
    for (int j = 0; j < 8; j++) begin
      entropy_enc_raddr = 8'(64 + j);
      @(negedge clock);
      checkOutput("scratch", int'(entropy_enc_rdata), scr[j]);
    end

    dct_flag = 1'b0;
    repeat (4) @(negedge clock);

    // Single block, samples 4k, last-flagged.
    $display("[TB] decode single block");
    for (int k = 0; k < 64; k++) blk[k] = 4 * k;
    finBase     = finCount;
    firstPixCyc = -1;
    lastPixCyc  = -1;
    applyStimulus(1'b1, 1'b1);
    checkOutput("singleReady", int'(idct_ready), 1);
    waitDrain(2000);
    checkOutput("firstPixLatency", firstPixCyc - completeCyc, 3);
    checkOutput("singleFinish", finCount - finBase, 1);
    checkOutput("singleReadyAfter", int'(idct_ready), 1);

    // Saturation corners plus random samples, not last-flagged.
    $display("[TB] saturation");
    for (int k = 0; k < 64; k++) blk[k] = randSample();
    blk[0] = 4095;
    blk[1] = -4096;
    blk[2] = 252;
    blk[3] = -6;
    begin
      exp_t e;
      e.fin = 1'b0;
      e.pix = 127;  expQ.push_back(e);
      e.pix = -128; expQ.push_back(e);
      e.pix = 63;   expQ.push_back(e);
      e.pix = -2;   expQ.push_back(e);
      for (int k = 4; k < 64; k++) begin
        e.pix = refPixel(blk[k]);
        expQ.push_back(e);
      end
    end
    finBase    = finCount;
    lastPixCyc = -1;
    applyStimulus(1'b0, 1'b0);
    waitDrain(2000);
    checkOutput("satNoFinish", finCount - finBase, 0);

    // Backpressure: third back-to-back block arrives while full and is dropped.
    $display("[TB] backpressure");
    popBase    = popCount;
    lastPixCyc = -1;
    for (int k = 0; k < 64; k++) blk[k] = randSample();
    applyStimulus(1'($urandom_range(0, 1)), 1'b1);
    checkOutput("bpReady1", int'(idct_ready), 1);
    for (int k = 0; k < 64; k++) blk[k] = randSample();
    applyStimulus(1'($urandom_range(0, 1)), 1'b1);
    checkOutput("bpReady2", int'(idct_ready), 0);
    checkOutput("bpOvfBefore", int'(overflow), 0);
    for (int k = 0; k < 64; k++) blk[k] = randSample();
    applyStimulus(1'b1, 1'b0);
    checkOutput("bpOvf", int'(overflow), 1);
    checkOutput("bpReady3", int'(idct_ready), 0);
    waitDrain(3000);
    repeat (300) @(negedge clock);
    checkOutput("bpPixels", popCount - popBase, 128);
    checkOutput("bpReadyAfter", int'(idct_ready), 1);

    // Continuous: one block every 256 clocks, drains must abut.
    $display("[TB] continuous");
    popBase    = popCount;
    lastPixCyc = -1;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 64; k++) blk[k] = randSample();
      applyStimulus(1'($urandom_range(0, 1)), 1'b1);
      repeat (192) @(negedge clock);
    end
    waitDrain(3000);
    checkOutput("contPixels", popCount - popBase, 256);
    checkOutput("overflowSticky", int'(overflow), 1);

    // Abort: raise dct_flag mid-drain with two blocks queued.
    $display("[TB] abort");
    lastPixCyc = -1;
    for (int k = 0; k < 64; k++) blk[k] = randSample();
    applyStimulus(1'b1, 1'b1);
    for (int k = 0; k < 64; k++) blk[k] = randSample();
    applyStimulus(1'b1, 1'b1);
    waitPixels(10, 2000);
    dct_flag = 1'b1;
    abortCyc = cyc;
    finBase  = finCount;
    late     = 0;
    repeat (20) begin
      @(negedge clock);
      if (decompress_data_en && cyc > abortCyc + 2) late++;
    end
    expQ.delete();
    checkOutput("abortLateStrobes", late, 0);
    checkOutput("abortFinish", finCount - finBase, 0);
    checkOutput("abortReady", int'(idct_ready), 1);
    dct_flag = 1'b0;
    repeat (10) @(negedge clock);
    lastPixCyc = -1;
    finBase    = finCount;
    for (int k = 0; k < 64; k++) blk[k] = randSample();
    applyStimulus(1'b1, 1'b1);
    waitDrain(2000);
    checkOutput("postAbortFinish", finCount - finBase, 1);

    // Reset in the middle of a drain.
    $display("[TB] reset mid-drain");
    lastPixCyc = -1;
    lf = 1'($urandom_range(0, 1));
    for (int k = 0; k < 64; k++) blk[k] = randSample();
    applyStimulus(lf, 1'b1);
    waitPixels(5, 2000);
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    expQ.delete();
    @(negedge clock);
    reset_n    = 1'b1;
    lastPixCyc = -1;
    popBase    = popCount;
    repeat (300) @(negedge clock);
    checkOutput("postResetPixels", popCount - popBase, 0);
    checkOutput("postResetReady", int'(idct_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
